key_schedule_gen: RTL and testbench

Sequential AES-128 key expansion engine. It accepts a 128-bit cipher key and emits the 11 round keys (rounds 0–10) one at a time over a valid/ready stream. SubWord is computed by four instances of the team's registered `SBox` byte-substitution module. The block sits beside the round datapath and feeds each AddRoundKey stage in order.

---
 rtl/aes_pkg.sv | 55 +++++
 rtl/SBox.sv | 19 +
 rtl/sub_word.sv | 19 +
 rtl/key_schedule_gen.sv | 112 +++++++++++
 tb/tb_key_schedule_gen.sv | 270 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/aes_pkg.sv
// Shared AES definitions: key-schedule state encoding, round constants and
// GF(2^8) helpers used by the key expansion and the byte-substitution logic.
package aes_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EMIT = 2'd1,
        ST_SUB  = 2'd2,
        ST_MIX  = 2'd3
    } ks_state_e;

    localparam int         AES128_ROUNDS = 10;
    localparam logic [7:0] RCON_INIT     = 8'h01;

    // Multiply by x in GF(2^8) modulo the AES polynomial x^8+x^4+x^3+x+1.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] rot_word(input logic [31:0] w);
        return {w[23:0], w[31:24]};
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] sh;
        acc = 8'h00;
        sh  = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) acc = acc ^ sh;
            sh = xtime(sh);
        end
        return acc;
    endfunction

    // Inverse as x^254 via an addition chain; maps 0 to 0 as the S-box requires.
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] x3, x7, x15, x31, x63, x127;
        x3   = gf_mul(gf_mul(x, x), x);
        x7   = gf_mul(gf_mul(x3, x3), x);
        x15  = gf_mul(gf_mul(x7, x7), x);
        x31  = gf_mul(gf_mul(x15, x15), x);
        x63  = gf_mul(gf_mul(x31, x31), x);
        x127 = gf_mul(gf_mul(x63, x63), x);
        return gf_mul(x127, x127);
    endfunction

    function automatic logic [7:0] sbox_byte(input logic [7:0] x);
        logic [7:0] b;
        b = gf_inv(x);
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]}
                 ^ {b[3:0], b[7:4]} ^ 8'h63;
    endfunction

endpackage

// File: rtl/SBox.sv
// AES forward S-box for one byte with a registered output (one cycle latency).
// The output register carries no reset; consumers only sample it after a valid load.
module SBox
    import aes_pkg::*;
(
    input  logic       clk,
    input  logic [7:0] in_i,
    output logic [7:0] out_o
);

    logic [7:0] out_q;

    always_ff @(posedge clk) begin
        out_q <= sbox_byte(in_i);
    end

    assign out_o = out_q;

endmodule

// File: rtl/sub_word.sv
// SubWord: four S-box lanes over a 32-bit word, one cycle latency.
// Shared between the key schedule and the round datapath.
module sub_word (
    input  logic        clk,
    input  logic [31:0] word_i,
    output logic [31:0] word_o
);

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            SBox u_sbox (
                .clk   (clk),
                .in_i  (word_i[8*gi +: 8]),
                .out_o (word_o[8*gi +: 8])
            );
        end
    endgenerate

endmodule

// File: rtl/key_schedule_gen.sv
// Sequential AES-128 key expansion: emits round keys 0..NUM_ROUNDS over a
// valid/ready stream, producing each new key in three cycles (EMIT, SUB, MIX).
module key_schedule_gen
    import aes_pkg::*;
#(
    parameter int NUM_ROUNDS = AES128_ROUNDS
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         key_valid,
    output logic         key_ready,
    input  logic [127:0] key_in,
    output logic         rk_valid,
    input  logic         rk_ready,
    output logic [3:0]   rk_index,
    output logic [127:0] round_key,
    output logic         busy
);

    ks_state_e    state_q;
    logic [127:0] round_key_q;
    logic [3:0]   rk_index_q;
    logic [7:0]   rcon_q;
    logic         rk_valid_q;
    logic         key_ready_q;
    logic         busy_q;

    logic [31:0]  sub_in;
    logic [31:0]  sub_out;
    logic [31:0]  temp_w;
    logic [127:0] mix_key;

    // The S-box input is w3 of the current key in every state; only the value
    // loaded during SUB is consumed, because round_key_q is stable until MIX.
    assign sub_in = rot_word(round_key_q[31:0]);

    sub_word u_sub_word (
        .clk    (clk),
        .word_i (sub_in),
        .word_o (sub_out)
    );

    always_comb begin
        temp_w           = sub_out ^ {rcon_q, 24'h0};
        mix_key          = '0;
        mix_key[127:96]  = round_key_q[127:96] ^ temp_w;
        mix_key[95:64]   = round_key_q[95:64]  ^ mix_key[127:96];
        mix_key[63:32]   = round_key_q[63:32]  ^ mix_key[95:64];
        mix_key[31:0]    = round_key_q[31:0]   ^ mix_key[63:32];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            round_key_q <= '0;
            rk_index_q  <= '0;
            rcon_q      <= RCON_INIT;
            rk_valid_q  <= 1'b0;
            key_ready_q <= 1'b1;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (key_valid) begin
                        round_key_q <= key_in;
                        rk_index_q  <= '0;
                        rcon_q      <= RCON_INIT;
                        rk_valid_q  <= 1'b1;
                        key_ready_q <= 1'b0;
                        busy_q      <= 1'b1;
                        state_q     <= ST_EMIT;
                    end
                end
                ST_EMIT: begin
                    if (rk_ready) begin
                        rk_valid_q <= 1'b0;
                        if (rk_index_q == 4'(NUM_ROUNDS)) begin
                            key_ready_q <= 1'b1;
                            busy_q      <= 1'b0;
                            state_q     <= ST_IDLE;
                        end else begin
                            state_q <= ST_SUB;
                        end
                    end
                end
                ST_SUB: begin
                    state_q <= ST_MIX;
                end
                ST_MIX: begin
                    round_key_q <= mix_key;
                    rk_index_q  <= rk_index_q + 4'd1;
                    rcon_q      <= xtime(rcon_q);
                    rk_valid_q  <= 1'b1;
                    state_q     <= ST_EMIT;
                end
                default: begin
                    rk_valid_q  <= 1'b0;
                    key_ready_q <= 1'b1;
                    busy_q      <= 1'b0;
                    state_q     <= ST_IDLE;
                end
            endcase
        end
    end

    assign key_ready = key_ready_q;
    assign rk_valid  = rk_valid_q;
    assign rk_index  = rk_index_q;
    assign round_key = round_key_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_key_schedule_gen.sv
// Self-checking bench for key_schedule_gen against a word-array key expansion
// model built from a literal S-box table and the round-constant list.
module tb_key_schedule_gen;

    logic         clk;
    logic         reset;
    logic         key_valid;
    logic         key_ready;
    logic [127:0] key_in;
    logic         rk_valid;
    logic         rk_ready;
    logic [3:0]   rk_index;
    logic [127:0] round_key;
    logic         busy;

    int total = 0;
    int bad   = 0;

    logic [2047:0] sbox_flat;
    logic [7:0]    rcon_tab [1:10];
    logic [127:0]  exp_rk [0:10];
    logic [127:0]  got_rk [0:10];

    localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] ZERO_KEY = 128'h0;

    key_schedule_gen #(.NUM_ROUNDS(10)) dut (
        .clk       (clk),
        .reset     (reset),
        .key_valid (key_valid),
        .key_ready (key_ready),
        .key_in    (key_in),
        .rk_valid  (rk_valid),
        .rk_ready  (rk_ready),
        .rk_index  (rk_index),
        .round_key (round_key),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] sb(input logic [7:0] x);
        int idx;
        idx = 2047 - 8 * int'(x);
        return sbox_flat[idx -: 8];
    endfunction

    // Standard 44-word expansion: w[i] = w[i-4] ^ f(w[i-1]).
    task automatic model(input logic [127:0] key);
        logic [31:0] w [0:43];
        logic [31:0] t;
        for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sb(t[31:24]), sb(t[23:16]), sb(t[15:8]), sb(t[7:0])};
                t = t ^ {rcon_tab[i/4], 24'h0};
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r <= 10; r++) exp_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    task automatic start_key(input logic [127:0] key);
        chk("key_ready_before_start", 128'(key_ready), 128'd1);
        key_in    = key;
        key_valid = 1'b1;
        step();
        key_valid = 1'b0;
    endtask

    // Full expansion with rk_ready held high; checks exact cycle placement.
    task automatic run_timed(input logic [127:0] key, input int pulse_k, input logic [127:0] other);
        model(key);
        rk_ready = 1'b1;
        start_key(key);
        for (int k = 0; k <= 10; k++) begin
            chk($sformatf("r%0d_valid", k), 128'(rk_valid), 128'd1);
            chk($sformatf("r%0d_index", k), 128'(rk_index), 128'(k));
            chk($sformatf("r%0d_key", k), round_key, exp_rk[k]);
            chk($sformatf("r%0d_busy", k), 128'(busy), 128'd1);
            got_rk[k] = round_key;
            if (k == pulse_k) begin
                key_in    = other;
                key_valid = 1'b1;
                chk("key_ready_while_busy", 128'(key_ready), 128'd0);
            end
            if (k < 10) begin
                step();
                chk($sformatf("r%0d_gap1", k), 128'(rk_valid), 128'd0);
                step();
                chk($sformatf("r%0d_gap2", k), 128'(rk_valid), 128'd0);
                step();
            end else begin
                step();
            end
            if (k == pulse_k) begin
                key_valid = 1'b0;
                key_in    = key;
            end
        end
        chk("end_key_ready", 128'(key_ready), 128'd1);
        chk("end_busy", 128'(busy), 128'd0);
        chk("end_rk_valid", 128'(rk_valid), 128'd0);
    endtask

    // Handshake-driven consumer from round start_k; rk_ready optionally random.
    task automatic consume(input int start_k, input bit rand_bp);
        for (int k = start_k; k <= 10; k++) begin
            int waited;
            bit done;
            waited = 0;
            done   = 1'b0;
            while (!done) begin
                if (rk_valid) begin
                    chk($sformatf("c%0d_index", k), 128'(rk_index), 128'(k));
                    chk($sformatf("c%0d_key", k), round_key, exp_rk[k]);
                    rk_ready = rand_bp ? 1'($urandom_range(0, 1)) : 1'b1;
                    done     = rk_ready;
                end else begin
                    rk_ready = rand_bp ? 1'($urandom_range(0, 1)) : 1'b1;
                end
                step();
                waited++;
                if (!done && waited > 40) begin
                    chk($sformatf("c%0d_timeout", k), 128'(rk_valid), 128'd1);
                    rk_ready = 1'b1;
                    return;
                end
            end
        end
        rk_ready = 1'b1;
        chk("c_end_key_ready", 128'(key_ready), 128'd1);
        chk("c_end_busy", 128'(busy), 128'd0);
        chk("c_end_rk_valid", 128'(rk_valid), 128'd0);
    endtask

    initial begin
        sbox_flat = {
            128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
            128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
            128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
            128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
            128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
            128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
            128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
            128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};
        rcon_tab = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};

        reset     = 1'b1;
        key_valid = 1'b0;
        key_in    = '0;
        rk_ready  = 1'b1;
        #2;
        chk("rst_rk_valid", 128'(rk_valid), 128'd0);
        chk("rst_rk_index", 128'(rk_index), 128'd0);
        chk("rst_round_key", round_key, 128'd0);
        chk("rst_busy", 128'(busy), 128'd0);
        chk("rst_key_ready", 128'(key_ready), 128'd1);
        step();
        step();
        reset = 1'b0;
        step();

        // FIPS-197 key, then the all-zero key back-to-back.
        run_timed(FIPS_KEY, 99, '0);
        chk("fips_r1_const", got_rk[1], 128'ha0fafe1788542cb123a339392a6c7605);
        chk("fips_r10_const", got_rk[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        run_timed(ZERO_KEY, 99, '0);
        chk("zero_r0_const", got_rk[0], 128'h0);
        chk("zero_r1_const", got_rk[1], 128'h62636363626363636263636362636363);
        chk("zero_r10_const", got_rk[10], 128'hb4ef5bcb3e92e21123e951cf6f8f188e);

        // A different key offered during round 5 must be ignored.
        step();
        run_timed(FIPS_KEY, 5, 128'h00112233445566778899aabbccddeeff);
        chk("busy_key_r10_const", got_rk[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

        // Backpressure on round 3 for five cycles.
        step();
        model(FIPS_KEY);
        rk_ready = 1'b1;
        start_key(FIPS_KEY);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("bp_r%0d_key", k), round_key, exp_rk[k]);
            step();
            if (k == 2) rk_ready = 1'b0;
            step();
            step();
        end
        chk("bp_r3_valid", 128'(rk_valid), 128'd1);
        chk("bp_r3_index", 128'(rk_index), 128'd3);
        for (int i = 0; i < 5; i++) begin
            step();
            chk($sformatf("bp_hold%0d_valid", i), 128'(rk_valid), 128'd1);
            chk($sformatf("bp_hold%0d_index", i), 128'(rk_index), 128'd3);
            chk($sformatf("bp_hold%0d_key", i), round_key, exp_rk[3]);
        end
        rk_ready = 1'b1;
        step();
        chk("bp_rel_gap0", 128'(rk_valid), 128'd0);
        step();
        chk("bp_rel_gap1", 128'(rk_valid), 128'd0);
        step();
        chk("bp_r4_valid", 128'(rk_valid), 128'd1);
        consume(4, 1'b0);

        // Random keys with random backpressure.
        for (int n = 0; n < 4; n++) begin
            logic [127:0] rkey;
            rkey = {$urandom(), $urandom(), $urandom(), $urandom()};
            step();
            model(rkey);
            start_key(rkey);
            consume(0, 1'b1);
        end

        // Reset asserted in the MIX cycle that would produce round 5.
        step();
        model(FIPS_KEY);
        rk_ready = 1'b1;
        start_key(FIPS_KEY);
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("mr_r%0d_key", k), round_key, exp_rk[k]);
            step();
            step();
            if (k < 4) step();
        end
        reset = 1'b1;
        #1;
        chk("mr_rk_valid", 128'(rk_valid), 128'd0);
        chk("mr_round_key", round_key, 128'd0);
        chk("mr_key_ready", 128'(key_ready), 128'd1);
        chk("mr_busy", 128'(busy), 128'd0);
        chk("mr_rk_index", 128'(rk_index), 128'd0);
        step();
        reset = 1'b0;
        step();
        chk("mr_post_rk_valid", 128'(rk_valid), 128'd0);
        step();
        chk("mr_post_rk_valid2", 128'(rk_valid), 128'd0);
        run_timed(FIPS_KEY, 99, '0);
        chk("mr_fips_r10_const", got_rk[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
